matvec_mul: RTL and testbench



---
 rtl/matvec_mul_if.sv | 24 ++
 rtl/matvec_mul.sv | 106 ++++++++++
 tb/tb_matvec_mul.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/matvec_mul_if.sv
// Operand/result bundle between matvec_mul and its upstream/downstream logic.
// master drives matrix/vec/singular; slave (the multiplier) returns result and flags.
interface matvec_mul_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int MATRIX_SIZE = 3
);
    logic [MATRIX_SIZE*MATRIX_SIZE*DATA_WIDTH-1:0] matrix;
    logic [MATRIX_SIZE*DATA_WIDTH-1:0]             vec;
    logic                                          singular;
    logic                                          complete;
    logic [MATRIX_SIZE*DATA_WIDTH-1:0]             result;
    logic                                          overflow;
    logic                                          o_singular;

    modport master (
        output matrix, vec, singular,
        input  complete, result, overflow, o_singular
    );

    modport slave (
        input  matrix, vec, singular,
        output complete, result, overflow, o_singular
    );
endinterface

// File: rtl/matvec_mul.sv
// x = A*b with one signed MAC per cycle; complete after N*N+2 edges (2 if singular).
// No backpressure: inputs are latched once in LOAD, outputs hold in DONE until rst.
module matvec_mul #(
    parameter int DATA_WIDTH  = 16,
    parameter int BIN_POS     = 8,
    parameter int MATRIX_SIZE = 3
) (
    input  logic         clk,
    input  logic         rst,
    matvec_mul_if.slave  bus
);
    localparam int N     = MATRIX_SIZE;
    localparam int DW    = DATA_WIDTH;
    localparam int PW    = 2 * DW;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int ACC_W = PW + $clog2(N) + 1;

    typedef enum logic [1:0] {LOAD, MAC, DONE} state_t;

    state_t                   state, state_nxt;
    logic [N*N*DW-1:0]        a_q;
    logic [N*DW-1:0]          b_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic [CNT_W-1:0]         row_q, col_q;
    logic [N*DW-1:0]          result_q;
    logic                     overflow_q;
    logic                     sing_q;
    logic                     complete_q;

    logic signed [DW-1:0]     a_elem, b_elem;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  sum, shifted;
    logic [DW-1:0]            sat_val;
    logic                     sat, last_col, last_row;

    always_comb begin
        a_elem   = a_q[(int'(row_q) * N + int'(col_q)) * DW +: DW];
        b_elem   = b_q[int'(col_q) * DW +: DW];
        prod     = PW'(a_elem) * PW'(b_elem);
        sum      = ((col_q == '0) ? '0 : acc_q) + ACC_W'(prod);
        shifted  = sum >>> BIN_POS;
        // Fits in DW bits only if everything from the DW sign bit upward is a sign copy
        sat      = ~((&shifted[ACC_W-1:DW-1]) | ~(|shifted[ACC_W-1:DW-1]));
        sat_val  = shifted[DW-1:0];
        if (sat) begin
            sat_val = shifted[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
        last_col = (col_q == CNT_W'(N - 1));
        last_row = (row_q == CNT_W'(N - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = bus.singular ? DONE : MAC;
            MAC:     if (last_col && last_row) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            sing_q     <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    a_q    <= bus.matrix;
                    b_q    <= bus.vec;
                    sing_q <= bus.singular;
                end
                MAC: begin
                    acc_q <= sum;
                    if (last_col) begin
                        result_q[int'(row_q) * DW +: DW] <= sat_val;
                        if (sat) overflow_q <= 1'b1;
                        col_q <= '0;
                        if (!last_row) row_q <= row_q + CNT_W'(1);
                    end else begin
                        col_q <= col_q + CNT_W'(1);
                    end
                end
                DONE:    complete_q <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.complete   = complete_q;
    assign bus.result     = result_q;
    assign bus.overflow   = overflow_q;
    assign bus.o_singular = sing_q;
endmodule

// File: tb/tb_matvec_mul.sv
// Scoreboarded bench for matvec_mul at 16-bit Q8, N=3.
module tb_matvec_mul;
    localparam int DW = 16;
    localparam int BP = 8;
    localparam int N  = 3;
    localparam int MW = N * N * DW;
    localparam int VW = N * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    matvec_mul_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(N)) bus ();
    matvec_mul #(.DATA_WIDTH(DW), .BIN_POS(BP), .MATRIX_SIZE(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [VW-1:0] res;
        logic          ovf;
        logic          sng;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [VW-1:0] res, input logic ovf, input logic sng, input int lat);
        exp_t e;
        e.res = res; e.ovf = ovf; e.sng = sng; e.lat = lat;
        return e;
    endfunction

    function automatic logic [VW-1:0] v3(input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] x2);
        return {x2, x1, x0};
    endfunction

    function automatic logic [MW-1:0] mat_fill(input logic [DW-1:0] x);
        logic [MW-1:0] m;
        for (int i = 0; i < N * N; i++) m[i*DW +: DW] = x;
        return m;
    endfunction

    function automatic logic [MW-1:0] mat_ident();
        logic [MW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[(i*N+i)*DW +: DW] = 16'h0100;
        return m;
    endfunction

    // Integer reference: exact dot product, floor shift, clamp to the signed DW range
    task automatic model(input logic [MW-1:0] m, input logic [VW-1:0] v,
                         output logic [VW-1:0] res, output logic ovf);
        longint s, hi, lo;
        hi  = (longint'(1) <<< (DW - 1)) - 1;
        lo  = -(longint'(1) <<< (DW - 1));
        ovf = 1'b0;
        res = '0;
        for (int r = 0; r < N; r++) begin
            s = 0;
            for (int c = 0; c < N; c++)
                s += longint'($signed(m[(r*N+c)*DW +: DW])) * longint'($signed(v[c*DW +: DW]));
            s = s >>> BP;
            if (s > hi) begin s = hi; ovf = 1'b1; end
            else if (s < lo) begin s = lo; ovf = 1'b1; end
            res[r*DW +: DW] = s[DW-1:0];
        end
    endtask

    task automatic scramble_inputs();
        for (int i = 0; i < N * N; i++) bus.matrix[i*DW +: DW] = DW'($urandom);
        for (int i = 0; i < N; i++) bus.vec[i*DW +: DW] = DW'($urandom);
        bus.singular = ~bus.singular;
    endtask

    task automatic run_case(input string name, input logic [MW-1:0] m, input logic [VW-1:0] v,
                            input logic s, input exp_t e);
        exp_t got;
        int   rise;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b1; bus.matrix = m; bus.vec = v; bus.singular = s;
        @(posedge clk); #1;
        chk($sformatf("%s rst complete", name), 64'(bus.complete), 64'd0);
        chk($sformatf("%s rst result", name), 64'(bus.result), 64'd0);
        chk($sformatf("%s rst flags", name), 64'({bus.overflow, bus.o_singular}), 64'd0);
        @(negedge clk);
        rst  = 1'b0;
        rise = 0;
        for (int ed = 1; ed <= 40 && rise == 0; ed++) begin
            @(posedge clk); #1;
            if (ed == 1) scramble_inputs();
            if (!e.sng)
                for (int r = 0; r < N; r++)
                    if (ed == 2 + r * N + (N - 1))
                        chk($sformatf("%s row%0d@edge%0d", name, r, ed),
                            64'(bus.result[r*DW +: DW]), 64'(e.res[r*DW +: DW]));
            if (bus.complete) rise = ed;
        end
        got = sb.pop_front();
        chk($sformatf("%s complete edge", name), 64'(rise), 64'(got.lat));
        chk($sformatf("%s result", name), 64'(bus.result), 64'(got.res));
        chk($sformatf("%s overflow", name), 64'(bus.overflow), 64'(got.ovf));
        chk($sformatf("%s o_singular", name), 64'(bus.o_singular), 64'(got.sng));
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("%s hold complete", name), 64'(bus.complete), 64'd1);
        chk($sformatf("%s hold result", name), 64'(bus.result), 64'(got.res));
    endtask

    task automatic abort_run();
        @(negedge clk);
        rst = 1'b1; bus.matrix = mat_ident(); bus.vec = v3(16'h0100, 16'h0200, 16'hFD00); bus.singular = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("abort row0 early", 64'(bus.result[DW-1:0]), 64'h0100);
        chk("abort complete low", 64'(bus.complete), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort result", 64'(bus.result), 64'd0);
        chk("abort complete", 64'(bus.complete), 64'd0);
        chk("abort flags", 64'({bus.overflow, bus.o_singular}), 64'd0);
    endtask

    initial begin
        logic [MW-1:0] m;
        logic [VW-1:0] v, r;
        logic          o;

        bus.matrix = '0; bus.vec = '0; bus.singular = 1'b0;
        repeat (2) @(posedge clk);

        run_case("ident", mat_ident(), v3(16'h0100, 16'h0200, 16'hFD00), 1'b0,
                 mk_exp(v3(16'h0100, 16'h0200, 16'hFD00), 1'b0, 1'b0, 11));
        run_case("frac", mat_fill(16'h0080), v3(16'h0100, 16'h0100, 16'h0100), 1'b0,
                 mk_exp(v3(16'h0180, 16'h0180, 16'h0180), 1'b0, 1'b0, 11));
        m = '0; m[DW-1:0] = 16'hFFFF;
        run_case("negtrunc", m, v3(16'h0080, 16'h0000, 16'h0000), 1'b0,
                 mk_exp(v3(16'hFFFF, 16'h0000, 16'h0000), 1'b0, 1'b0, 11));
        run_case("satpos", mat_fill(16'h7F00), v3(16'h7F00, 16'h7F00, 16'h7F00), 1'b0,
                 mk_exp(v3(16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b1, 1'b0, 11));
        run_case("satneg", mat_fill(16'h7F00), v3(16'h8100, 16'h8100, 16'h8100), 1'b0,
                 mk_exp(v3(16'h8000, 16'h8000, 16'h8000), 1'b1, 1'b0, 11));
        run_case("singular", mat_fill(16'h1234), v3(16'h0100, 16'h7F00, 16'h8000), 1'b1,
                 mk_exp('0, 1'b0, 1'b1, 2));

        abort_run();
        run_case("after_abort", mat_ident(), v3(16'h0300, 16'h0000, 16'h0000), 1'b0,
                 mk_exp(v3(16'h0300, 16'h0000, 16'h0000), 1'b0, 1'b0, 11));

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N * N; i++) m[i*DW +: DW] = DW'($urandom_range(0, 2047)) - 16'd1024;
            for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom_range(0, 2047)) - 16'd1024;
            model(m, v, r, o);
            run_case($sformatf("rand%0d", k), m, v, 1'b0, mk_exp(r, o, 1'b0, 11));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
